// File: rtl/huff_dc_sched_pkg.sv
// +-----------------------------------------------------------------------+
// | huff_dc_pkg : shared types, field offsets and DC difference helper    |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
`default_nettype none

package huff_dc_pkg;

  localparam int ENC_OUT_W = 24;
  localparam int DC_W      = 8;
  localparam int CODE_LSB  = 16;
  localparam int LEN_LSB   = 8;
  localparam int VAL_LSB   = 0;
  localparam int FIFO_W    = ENC_OUT_W + 3;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    comp_e comp;
    logic  mcu_last;
    logic  valid;
  } tag_t;

  // a - b on sign-extended operands; the 9-bit result overflows 8 bits
  // exactly when its two top bits disagree.
  function automatic logic [DC_W-1:0] sat_sub(input logic [DC_W-1:0] a,
                                               input logic [DC_W-1:0] b);
    logic [DC_W:0] d;
    d = {a[DC_W-1], a} - {b[DC_W-1], b};
    if (d[DC_W] != d[DC_W-1])
      return d[DC_W] ? {1'b1, {(DC_W-1){1'b0}}} : {1'b0, {(DC_W-1){1'b1}}};
    return d[DC_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/huff_dc_sched_if.sv
// +-----------------------------------------------------------------------+
// | huff_dc_sched_if : block input, encoder and result-FIFO signals        |
// | Optional stats ports under HUFF_DC_SCHED_STATS_EN. Revision : 1.0     |
// +-----------------------------------------------------------------------+
`default_nettype none

interface huff_dc_sched_if;
  import huff_dc_pkg::*;

  logic                 restart;
  logic                 flush;
  logic                 flush_done;
  logic                 blk_valid;
  logic                 blk_ready;
  logic [DC_W-1:0]      blk_dc;
  logic [DC_W-1:0]      enc_dc;
  logic                 enc_is_luminance;
  logic [ENC_OUT_W-1:0] enc_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [ENC_OUT_W-1:0] out_code;
  logic [1:0]           out_comp;
  logic                 out_mcu_last;
`ifdef HUFF_DC_SCHED_STATS_EN
  logic [31:0]          stat_blocks;
  logic [31:0]          stat_bits;

  modport slave (
    input  restart, flush, blk_valid, blk_dc, enc_out, out_ready,
    output flush_done, blk_ready, enc_dc, enc_is_luminance,
           out_valid, out_code, out_comp, out_mcu_last, stat_blocks, stat_bits
  );
  modport master (
    output restart, flush, blk_valid, blk_dc, enc_out, out_ready,
    input  flush_done, blk_ready, enc_dc, enc_is_luminance,
           out_valid, out_code, out_comp, out_mcu_last, stat_blocks, stat_bits
  );
`else
  modport slave (
    input  restart, flush, blk_valid, blk_dc, enc_out, out_ready,
    output flush_done, blk_ready, enc_dc, enc_is_luminance,
           out_valid, out_code, out_comp, out_mcu_last
  );
  modport master (
    output restart, flush, blk_valid, blk_dc, enc_out, out_ready,
    input  flush_done, blk_ready, enc_dc, enc_is_luminance,
           out_valid, out_code, out_comp, out_mcu_last
  );
`endif

endinterface

`default_nettype wire

// File: rtl/huff_dc_sched_out_fifo.sv
// +-----------------------------------------------------------------------+
// | huff_dc_out_fifo : synchronous result FIFO with occupancy count        |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module huff_dc_out_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 8
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  input  wire logic                         push_i,
  input  wire logic [WIDTH-1:0]             din_i,
  input  wire logic                         pop_i,
  output logic      [WIDTH-1:0]             dout_o,
  output logic      [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_cnt_w-1:0] count_q;
  logic               w_do_push, w_do_pop;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign w_do_push = push_i && (count_q != c_cnt_w'(DEPTH));
  assign w_do_pop  = pop_i && (count_q != '0);
  assign dout_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (w_do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (w_do_push && !w_do_pop)      count_q <= count_q + c_cnt_w'(1);
      else if (!w_do_push && w_do_pop) count_q <= count_q - c_cnt_w'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/huff_dc_sched.sv
// +-----------------------------------------------------------------------+
// | huff_dc_sched : DC predictor, credit-based encoder issue, result FIFO  |
// | Optional stats under HUFF_DC_SCHED_STATS_EN. Revision : 1.0           |
// +-----------------------------------------------------------------------+
`default_nettype none

module huff_dc_sched
  import huff_dc_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int ENC_LATENCY = 4,
  parameter int Y_PER_MCU   = 4
) (
  input wire logic       clk,
  input wire logic       rst_n,
  huff_dc_sched_if.slave bus
);

  localparam int c_slot_w = $clog2(Y_PER_MCU + 2);

  state_e                state_q, state_d;
  logic                  alive_q;
  logic [c_slot_w-1:0]   slot_q, slot_d;
  logic                  pend_q, pend_d;
  logic                  flush_done_q, flush_done_d;
  logic [DC_W-1:0]       enc_dc_q, enc_dc_d;
  logic                  lum_q, lum_d;
  logic [DC_W-1:0]       pred_q [3];
  logic [DC_W-1:0]       pred_d [3];
  tag_t                  tag_q  [ENC_LATENCY+1];
  tag_t                  tag_d;

  comp_e                 w_comp;
  logic                  w_lum, w_last, w_accept, w_pop;
  logic [DC_W-1:0]       w_diff;
  int                    w_inflight;
  logic [$clog2(FIFO_DEPTH+1)-1:0] w_fifo_count;
  logic [FIFO_W-1:0]     w_head;

  always_comb begin
    if (slot_q < c_slot_w'(Y_PER_MCU))       w_comp = COMP_Y;
    else if (slot_q == c_slot_w'(Y_PER_MCU)) w_comp = COMP_CB;
    else                                     w_comp = COMP_CR;
  end

  assign w_lum  = (w_comp == COMP_Y);
  assign w_last = (w_comp == COMP_CR);
  assign w_diff = sat_sub(bus.blk_dc, pred_q[w_comp]);

  // Entry 0 travels alongside enc_dc; entry ENC_LATENCY lines up with enc_out.
  always_comb begin
    w_inflight = 0;
    for (int i = 0; i <= ENC_LATENCY; i++)
      if (tag_q[i].valid) w_inflight++;
  end

  assign bus.blk_ready = alive_q && (state_q == ST_RUN) &&
                         ((int'(w_fifo_count) + w_inflight) < FIFO_DEPTH);
  assign w_accept      = bus.blk_valid && bus.blk_ready;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    pend_d       = pend_q;
    flush_done_d = 1'b0;
    enc_dc_d     = enc_dc_q;
    lum_d        = lum_q;
    pred_d       = pred_q;
    tag_d        = '0;
    if (w_accept) begin
      enc_dc_d       = w_diff;
      lum_d          = w_lum;
      pred_d[w_comp] = bus.blk_dc;
      tag_d          = '{comp: w_comp, mcu_last: w_last, valid: 1'b1};
      slot_d         = w_last ? '0 : slot_q + c_slot_w'(1);
    end
    if (bus.restart) pend_d = 1'b1;
    if (pend_d && ((!w_accept && slot_q == '0) || (w_accept && w_last))) begin
      for (int i = 0; i < 3; i++) pred_d[i] = '0;
      pend_d = 1'b0;
    end
    case (state_q)
      ST_RUN:   if (bus.flush) state_d = ST_DRAIN;
      ST_DRAIN: if (w_inflight == 0 && w_fifo_count == '0) begin
        flush_done_d = 1'b1;
        state_d      = ST_RUN;
        slot_d       = '0;
        pend_d       = 1'b0;
        for (int i = 0; i < 3; i++) pred_d[i] = '0;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      alive_q      <= 1'b0;
      slot_q       <= '0;
      pend_q       <= 1'b0;
      flush_done_q <= 1'b0;
      enc_dc_q     <= '0;
      lum_q        <= 1'b0;
      for (int i = 0; i < 3; i++) pred_q[i] <= '0;
      for (int i = 0; i <= ENC_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      alive_q      <= 1'b1;
      slot_q       <= slot_d;
      pend_q       <= pend_d;
      flush_done_q <= flush_done_d;
      enc_dc_q     <= enc_dc_d;
      lum_q        <= lum_d;
      pred_q       <= pred_d;
      tag_q[0]     <= tag_d;
      for (int i = 1; i <= ENC_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  huff_dc_out_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tag_q[ENC_LATENCY].valid),
    .din_i   ({bus.enc_out[CODE_LSB +: 8], bus.enc_out[LEN_LSB +: 8],
               bus.enc_out[VAL_LSB +: 8], tag_q[ENC_LATENCY].comp,
               tag_q[ENC_LATENCY].mcu_last}),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .count_o (w_fifo_count)
  );

  assign bus.out_valid        = (w_fifo_count != '0);
  assign w_pop                = bus.out_valid && bus.out_ready;
  assign bus.out_code         = bus.out_valid ? w_head[FIFO_W-1:3] : '0;
  assign bus.out_comp         = bus.out_valid ? w_head[2:1] : '0;
  assign bus.out_mcu_last     = bus.out_valid && w_head[0];
  assign bus.enc_dc           = enc_dc_q;
  assign bus.enc_is_luminance = lum_q;
  assign bus.flush_done       = flush_done_q;

`ifdef HUFF_DC_SCHED_STATS_EN
  logic [31:0] stat_blocks_q, stat_bits_q;
  logic [32:0] w_bits_sum;

  assign w_bits_sum = {1'b0, stat_bits_q} + 33'(bus.out_code[LEN_LSB +: 8]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_blocks_q <= '0;
      stat_bits_q   <= '0;
    end else if (flush_done_d) begin
      stat_blocks_q <= '0;
      stat_bits_q   <= '0;
    end else if (w_pop) begin
      if (stat_blocks_q != '1) stat_blocks_q <= stat_blocks_q + 32'd1;
      stat_bits_q <= w_bits_sum[32] ? '1 : w_bits_sum[31:0];
    end
  end

  assign bus.stat_blocks = stat_blocks_q;
  assign bus.stat_bits   = stat_bits_q;
`endif

endmodule

`default_nettype wire

// File: doc/huff_dc_sched.md
Name: huff_dc_sched

Overview:
- Front-end scheduler for the Huffman DC encoder pipeline.
- Accepts quantized DC coefficients one block at a time in MCU order. Keeps per-component DC predictors and computes each block's difference from its predictor.
- Issues the difference to the fixed-latency, non-stallable encoder with the correct luminance/chroma select, then collects the 24-bit results into an output FIFO with ready/valid backpressure.
- Credit-based issue guarantees no encoder result is ever dropped.

Parameters:
- FIFO_DEPTH, 8: output FIFO entries. Must be >= ENC_LATENCY+1.
- ENC_LATENCY, 4: clock edges from enc_dc valid to enc_out valid.
- Y_PER_MCU, 4: luminance blocks per MCU (1 = 4:4:4, 4 = 4:2:0). Each MCU is followed by 1 Cb block and 1 Cr block.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- restart  in  1  pulse; zero all predictors at the next MCU boundary
- flush  in  1  pulse; stop accepting and drain
- flush_done  out  1  one-cycle pulse when drain completes
- blk_valid  in  1  DC input valid
- blk_ready  out  1  DC input accepted when valid&ready
- blk_dc  in  8  signed quantized DC coefficient
- enc_dc  out  8  difference to encoder (drives matrix[7:0]; other matrix bits tied 0)
- enc_is_luminance  out  1  encoder table select
- enc_out  in  24  encoder result {code[7:0], length[7:0], value[7:0]}
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_code  out  24  encoder result, unchanged
- out_comp  out  2  0=Y, 1=Cb, 2=Cr
- out_mcu_last  out  1  result belongs to the Cr block (last block of the MCU)

Behaviour:
- Reset: blk_ready=0 during reset. out_valid, flush_done, enc_dc, enc_is_luminance, out_code, out_comp, out_mcu_last all 0. Predictors=0, slot=0, FIFO empty, valid pipe cleared, state RUN. blk_ready may rise on the first cycle after reset deassertion.
- Slot counter 0..Y_PER_MCU+1:
  - slots < Y_PER_MCU are Y (lum=1).
  - slot Y_PER_MCU is Cb; slot Y_PER_MCU+1 is Cr (lum=0).
  - Advances on each accepted block and wraps to 0 after Cr.
- Difference: diff = blk_dc - pred[comp], computed at 9 bits and saturated to [-128,127]. pred[comp] <= blk_dc on accept.
- Issue on the accept edge: enc_dc <= diff, enc_is_luminance <= lum. A tag {comp, mcu_last, valid=1} enters an ENC_LATENCY-deep shift register. On non-accept cycles the tag valid is 0 and enc_dc holds its value.
- Capture: when the tag exits the shift register, {enc_out, comp, mcu_last} is written to the FIFO. Latency is accept edge → out_valid high after 5 edges when the FIFO is empty and ENC_LATENCY=4.
- Credit rule: blk_ready = (state==RUN) && (fifo_count + inflight < FIFO_DEPTH). inflight = number of set tag valids. A pop in the same cycle is not credited.
- Output: FIFO head is shown on out_*. Pop on out_valid&out_ready. A push and a pop in the same cycle both take effect, and count is unchanged. The FIFO can never overflow; the bench asserts this.
- restart: latched as pending.
  - If slot==0 and no block is accepted that cycle, predictors clear immediately.
  - Otherwise they clear on the accept edge of the Cr block, after the Cr predictor update.
  - The next MCU always starts from predictors of 0.
- flush: state RUN→DRAIN, blk_ready=0. In DRAIN, wait until inflight==0 and the FIFO is empty, then pulse flush_done and enter RUN with slot=0 and predictors=0. Flush arriving in DRAIN is ignored. If flush arrives on a cycle with an accept, the block is accepted and issued first.
- Reset mid-operation discards the in-flight tags and the FIFO contents. Encoder-side pipeline garbage is ignored because tags are cleared.

Optional Feature:
- Macro HUFF_DC_SCHED_STATS_EN adds two outputs:
  - stat_blocks[31:0]: count of FIFO pops.
  - stat_bits[31:0]: sum of popped length fields.
- Both are saturating, reset to 0, and cleared by the flush_done pulse.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package huff_dc_pkg holds:
  - comp_e enum (COMP_Y=0, COMP_CB=1, COMP_CR=2).
  - ENC_OUT_W=24, DC_W=8.
  - Field offsets CODE_LSB=16, LEN_LSB=8, VAL_LSB=0.
  - The saturating-subtract function.
- One sub-module huff_dc_out_fifo: synchronous FIFO, width 27, with count output.

Test Plan:
- Y_PER_MCU=4; feed DC 5,5,5,5 then Cb 0, Cr 0, with the encoder model attached → enc_dc 5,0,0,0,0,0. Lum flags 1,1,1,1,0,0. Outputs 0x400305, then 0xC003FF ×3, 0x0202FF ×2. out_mcu_last only on the 6th result.
- Saturation: Y pred 100 (block 1), block 2 DC -100 → enc_dc=0x80 (-128). Then DC 127 after pred -100 → enc_dc=0x7F.
- Backpressure: out_ready=0 and blk_valid held → exactly 8 accepts, then blk_ready=0. Release out_ready → all 8 results delivered in order with none lost.
- restart pulsed at slot 2 → the remaining Y blocks of the MCU still use predictors. The first Y of the next MCU with DC 7 issues enc_dc=7.
- flush with 3 blocks in flight → blk_ready=0 immediately. flush_done pulses one cycle after the 3rd result is popped. The next block issues with slot 0 and predictor 0.
- Async reset asserted mid-burst → all outputs 0 within the reset cycle, no out_valid after release until new blocks arrive.
